// File: rtl/tcdm_banks_pipe_wrap.sv
// TCDM bank wrapper: NbBanks single-port SRAM banks behind flat HCI target ports,
// with a shared zero-initialisation FSM and a configurable-latency response pipeline.
module tcdm_banks_pipe_wrap #(
   parameter int unsigned BankSize  = 256,
   parameter int unsigned NbBanks   = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned BeWidth   = DataWidth / 8,
   parameter int unsigned IdWidth   = 1,
   parameter int unsigned RdLatency = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           init_trigger_i,
   output logic                           init_busy_o,
   input  logic [NbBanks-1:0]             req_i,
   output logic [NbBanks-1:0]             gnt_o,
   input  logic [NbBanks*AddrWidth-1:0]   add_i,
   input  logic [NbBanks-1:0]             wen_i,
   input  logic [NbBanks*DataWidth-1:0]   data_i,
   input  logic [NbBanks*BeWidth-1:0]     be_i,
   input  logic [NbBanks*IdWidth-1:0]     id_i,
   output logic [NbBanks-1:0]             r_valid_o,
   output logic [NbBanks*DataWidth-1:0]   r_data_o,
   output logic [NbBanks*IdWidth-1:0]     r_id_o
);

   localparam int unsigned IdxWidth = $clog2(BankSize);
   localparam int unsigned OffWidth = $clog2(BeWidth);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] cnt_q, cnt_d;
   logic                init_we;
   logic                run_en;
   logic                unused_addr;

   // Only the word-index bits of each address matter; the rest are deliberately dropped.
   assign unused_addr = ^add_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      run_en  = 1'b0;
      case (state_q)
         INIT: begin
            init_we = 1'b1;
            cnt_d   = cnt_q + IdxWidth'(1);
            if (cnt_q == IdxWidth'(BankSize - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            run_en = 1'b1;
            if (init_trigger_i) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset masks grants immediately so no handshake can slip through the reset cycle.
   assign init_busy_o = rst_i | ~run_en;
   assign gnt_o       = {NbBanks{run_en & ~rst_i}};

   for (genvar b = 0; b < NbBanks; b++) begin : gen_bank
      logic [DataWidth-1:0] mem_q [BankSize];
      logic [IdxWidth-1:0]  idx;
      logic [IdxWidth-1:0]  widx;
      logic [DataWidth-1:0] wdata;
      logic [BeWidth-1:0]   wbe;
      logic                 hs;
      logic                 rd_hs;
      logic                 wr_en;
      logic [RdLatency-1:0] valid_pipe_q;
      logic [IdWidth-1:0]   id_pipe_q   [RdLatency];
      logic [DataWidth-1:0] data_pipe_q [RdLatency];

      assign idx   = add_i[b*AddrWidth + OffWidth +: IdxWidth];
      assign hs    = req_i[b] & gnt_o[b];
      assign rd_hs = hs & wen_i[b];
      assign wr_en = init_we | (hs & ~wen_i[b]);
      assign widx  = init_we ? cnt_q : idx;
      assign wdata = init_we ? '0 : data_i[b*DataWidth +: DataWidth];
      assign wbe   = init_we ? '1 : be_i[b*BeWidth +: BeWidth];

      always_ff @(posedge clk_i) begin
         if (wr_en) begin
            for (int j = 0; j < int'(BeWidth); j++) begin
               if (wbe[j]) begin
                  mem_q[widx][j*8 +: 8] <= wdata[j*8 +: 8];
               end
            end
         end
      end

      // Stage 0 of the data pipe is the SRAM output register; later stages only add delay.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            valid_pipe_q <= '0;
            for (int i = 0; i < int'(RdLatency); i++) begin
               id_pipe_q[i]   <= '0;
               data_pipe_q[i] <= '0;
            end
         end else begin
            valid_pipe_q[0] <= hs;
            id_pipe_q[0]    <= hs ? id_i[b*IdWidth +: IdWidth] : '0;
            if (rd_hs) begin
               data_pipe_q[0] <= mem_q[idx];
            end
            for (int i = 1; i < int'(RdLatency); i++) begin
               valid_pipe_q[i] <= valid_pipe_q[i-1];
               id_pipe_q[i]    <= id_pipe_q[i-1];
               data_pipe_q[i]  <= data_pipe_q[i-1];
            end
         end
      end

      assign r_valid_o[b]                         = valid_pipe_q[RdLatency-1];
      assign r_id_o[b*IdWidth +: IdWidth]         = id_pipe_q[RdLatency-1];
      assign r_data_o[b*DataWidth +: DataWidth]   = data_pipe_q[RdLatency-1];
   end

endmodule
